fifo: RTL and testbench
=======================

FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the width of din/dout.
REQ-002 Parameter DEPTH, default 8, is the number of storage entries; it SHALL be a power of two.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port write, input, 1 bit: write request, sampled on the rising edge.
REQ-006 Port read, input, 1 bit: read request, sampled on the rising edge.
REQ-007 Port din, input, DATA_WIDTH: write data, captured when a write is accepted.
REQ-008 Port dout, output, DATA_WIDTH: registered read data.
REQ-009 Port fifo_empty, output, 1 bit: high when the occupancy is 0.
REQ-010 Port fifo_full, output, 1 bit: high when the occupancy equals DEPTH.
REQ-011 Port status_counter, output, 4 bits (log2(DEPTH)+1): current occupancy, 0..DEPTH.

Function
REQ-012 A write SHALL be accepted when write=1 and (fifo_full=0, or read is also accepted in the same cycle).
- Accepted write: din is stored at the write pointer, and the write pointer increments modulo DEPTH.
REQ-013 A read SHALL be accepted when read=1 and fifo_empty=0.
- Accepted read: dout takes the entry at the read pointer on that same edge, and the read pointer increments modulo DEPTH.
- Read latency: data is visible one clock edge after read is sampled.
REQ-014 dout SHALL hold its last value in every cycle without an accepted read.
REQ-015 Overflow: a write while full with no read SHALL be ignored; storage, pointers and count are unchanged, and no error flag is raised.
REQ-016 Underflow: a read while empty SHALL be ignored; dout and pointers are unchanged.
REQ-017 Simultaneous read and write, not empty: both are accepted and status_counter is unchanged.
- This includes the full case, where fifo_full stays 1.
REQ-018 Simultaneous read and write, empty: only the write is accepted; status_counter becomes 1 and dout is unchanged.
REQ-019 status_counter SHALL move as follows:
- increment by 1 on a write-only accepted cycle;
- decrement by 1 on a read-only accepted cycle;
- never leave the range 0..DEPTH.
REQ-020 fifo_empty and fifo_full SHALL be combinational decodes of status_counter, so they are valid in the same cycle the count changes.
REQ-021 Pointers SHALL wrap from DEPTH-1 to 0, and data order SHALL be strictly first-in first-out across any number of wraps.
REQ-022 Storage contents SHALL NOT be reset; only control state is reset.

Reset
REQ-023 When rst=1 at a rising edge, all of the following SHALL happen:
- read pointer, write pointer and status_counter become 0;
- dout becomes 0;
- fifo_empty=1 and fifo_full=0 from the following cycle.
REQ-024 Reset SHALL take priority over write and read in the same cycle; those requests are discarded.
REQ-025 Reset asserted mid-operation SHALL discard all stored entries logically; subsequent reads see only data written after reset.

Structure
REQ-026 A shared package fifo_pkg SHALL hold DATA_WIDTH, DEPTH, the derived pointer width (log2 DEPTH) and the count width (log2 DEPTH + 1).
REQ-027 The storage array SHALL be one sub-module, fifo_mem, with:
- a synchronous write port (we, waddr, wdata);
- a synchronous registered read port (re, raddr, rdata).
REQ-028 The fifo module SHALL contain the pointer, counter, flag and accept logic, and instantiate fifo_mem once.

Verification
REQ-029 Reset, then write 7 values 0x11, 0x22 … 0x77 on consecutive cycles:
- status_counter=7, fifo_empty=0, fifo_full=0.
REQ-030 Then read 7 consecutive cycles:
- dout = 0x11, 0x22 … 0x77, each one edge after its read is sampled;
- finally status_counter=0, fifo_empty=1, and dout holds 0x77.
REQ-031 Write 9 values 0x01..0x09 from empty:
- after the 8th, fifo_full=1 and status_counter=8;
- the 9th is dropped;
- 8 reads return 0x01..0x08.
REQ-032 Read while empty: dout and status_counter are unchanged.
- Simultaneous read and write at empty: count becomes 1, and the next read returns the written value.
REQ-033 Wrap and full case: fill to 8, then do 4 reads, then 4 writes (0xA1..0xA4), so the pointers wrap.
- Then a read+write at full: count stays 8.
- Drain order: remaining old entries, then 0xA1..0xA4, then the simultaneous-write value.
REQ-034 Assert rst with 5 entries stored: next cycle status_counter=0, fifo_empty=1, dout=0, and a subsequent read is ignored.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing defaults and the per-cycle operation encoding for the FIFO slice.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 8;
  localparam int FIFO_PTR_W      = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W      = FIFO_PTR_W + 1;

  // Bit 1 = write accepted, bit 0 = read accepted.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_t;

endpackage

// File: rtl/fifo_mem.sv
// Storage array: synchronous write port, registered read port (1-edge latency).
// No backpressure here; the caller only strobes we/re for accepted operations.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_W     = FIFO_PTR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; only the read register clears.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-address read+write returns the old entry, which is the FIFO head.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo.sv
// Synchronous FIFO: pointers, occupancy count, flags and accept logic around fifo_mem.
// Read data is registered (one edge after read); writes at full are dropped unless a read frees a slot.
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write,
  input  logic                       read,
  input  logic [DATA_WIDTH-1:0]      din,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic [$clog2(DEPTH):0]     status_counter
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             rd_acc;
  logic             wr_acc;
  fifo_op_t         op;

  assign fifo_empty = (status_counter == '0);
  assign fifo_full  = (status_counter == CNT_FULL);

  // A read at full frees the head slot in the same edge, so the write may proceed.
  assign rd_acc = read & ~fifo_empty;
  assign wr_acc = write & (~fifo_full | rd_acc);

  always_comb begin
    op = fifo_op_t'({wr_acc, rd_acc});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      status_counter <= '0;
    end else begin
      case (op)
        OP_WR: begin
          wr_ptr         <= wr_ptr + PTR_ONE;
          status_counter <= status_counter + CNT_ONE;
        end
        OP_RD: begin
          rd_ptr         <= rd_ptr + PTR_ONE;
          status_counter <= status_counter - CNT_ONE;
        end
        OP_RW: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_acc & ~rst),
    .raddr (rd_ptr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed table, corner-case sequences, then random traffic vs a queue model.
module tb_fifo;

  localparam int DW  = 8;
  localparam int DEP = 8;

  logic          clk;
  logic          rst;
  logic          write;
  logic          read;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          fifo_empty;
  logic          fifo_full;
  logic [3:0]    status_counter;

  int checks = 0;
  int errors = 0;

  // Reference model: plain queue of stored bytes plus the last value read out.
  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_dout;

  typedef struct {
    logic          rst;
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic [3:0]    cnt;
    logic          empty;
    logic          full;
  } vec_t;

  vec_t tbl [16];

  fifo #(.DATA_WIDTH(DW), .DEPTH(DEP)) dut (
    .clk            (clk),
    .rst            (rst),
    .write          (write),
    .read           (read),
    .din            (din),
    .dout           (dout),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .status_counter (status_counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of requests, let the edge happen, then advance the model.
  task automatic step(input logic r_s, input logic w_s, input logic rd_s, input logic [DW-1:0] d);
    bit rd_ok;
    bit wr_ok;
    rst   = r_s;
    write = w_s;
    read  = rd_s;
    din   = d;
    @(posedge clk);
    #1;
    if (r_s) begin
      mq.delete();
      m_dout = '0;
    end else begin
      rd_ok = rd_s && (mq.size() > 0);
      wr_ok = w_s && ((mq.size() < DEP) || rd_ok);
      if (rd_ok) m_dout = mq.pop_front();
      if (wr_ok) mq.push_back(d);
    end
    rst   = 1'b0;
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".dout"},  32'(dout),           32'(m_dout));
    chk({tag, ".count"}, 32'(status_counter), 32'(mq.size()));
    chk({tag, ".empty"}, 32'(fifo_empty),     32'(mq.size() == 0));
    chk({tag, ".full"},  32'(fifo_full),      32'(mq.size() == DEP));
  endtask

  task automatic step_chk(input string tag, input logic r_s, input logic w_s, input logic rd_s,
                          input logic [DW-1:0] d);
    step(r_s, w_s, rd_s, d);
    chk_model(tag);
  endtask

  initial begin
    logic [DW-1:0] drain_exp [12];
    rst   = 1'b0;
    write = 1'b0;
    read  = 1'b0;
    din   = '0;
    m_dout = '0;

    // Directed table: reset, seven writes 0x11..0x77, seven reads, one underflow read.
    tbl[0] = '{rst:1'b1, wr:1'b0, rd:1'b0, din:8'h00, dout:8'h00, cnt:4'd0, empty:1'b1, full:1'b0};
    for (int i = 1; i <= 7; i++)
      tbl[i] = '{rst:1'b0, wr:1'b1, rd:1'b0, din:8'(8'h11 * i), dout:8'h00,
                 cnt:4'(i), empty:1'b0, full:1'b0};
    for (int k = 1; k <= 7; k++)
      tbl[7+k] = '{rst:1'b0, wr:1'b0, rd:1'b1, din:8'hEE, dout:8'(8'h11 * k),
                   cnt:4'(7 - k), empty:(k == 7), full:1'b0};
    tbl[15] = '{rst:1'b0, wr:1'b0, rd:1'b1, din:8'hEE, dout:8'h77, cnt:4'd0, empty:1'b1, full:1'b0};

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk($sformatf("tbl%0d.dout", i),  32'(dout),           32'(tbl[i].dout));
      chk($sformatf("tbl%0d.count", i), 32'(status_counter), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.empty", i), 32'(fifo_empty),     32'(tbl[i].empty));
      chk($sformatf("tbl%0d.full", i),  32'(fifo_full),      32'(tbl[i].full));
    end

    // Overflow: nine writes from empty, the ninth is dropped.
    for (int i = 1; i <= 9; i++) begin
      step_chk($sformatf("ovf_wr%0d", i), 1'b0, 1'b1, 1'b0, 8'(i));
      if (i == 8) begin
        chk("ovf_full_at8", 32'(fifo_full), 32'd1);
        chk("ovf_count_at8", 32'(status_counter), 32'd8);
      end
    end
    chk("ovf_count_after9", 32'(status_counter), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      step_chk($sformatf("ovf_rd%0d", i), 1'b0, 1'b0, 1'b1, 8'h00);
      chk($sformatf("ovf_order%0d", i), 32'(dout), 32'(i));
    end

    // Underflow, then read+write at empty: only the write lands.
    step_chk("udf_rd", 1'b0, 1'b0, 1'b1, 8'h00);
    chk("udf_dout_hold", 32'(dout), 32'h08);
    step_chk("empty_rw", 1'b0, 1'b1, 1'b1, 8'h5A);
    chk("empty_rw_count", 32'(status_counter), 32'd1);
    chk("empty_rw_dout_hold", 32'(dout), 32'h08);
    step_chk("empty_rw_rd", 1'b0, 1'b0, 1'b1, 8'h00);
    chk("empty_rw_value", 32'(dout), 32'h5A);

    // Wrap and full read+write.
    step_chk("wrap_rst", 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step_chk($sformatf("wrap_fill%0d", i), 1'b0, 1'b1, 1'b0, 8'(8'hB1 + i));
    for (int i = 0; i < 4; i++) step_chk($sformatf("wrap_rd%0d", i), 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step_chk($sformatf("wrap_wr%0d", i), 1'b0, 1'b1, 1'b0, 8'(8'hA1 + i));
    chk("wrap_full", 32'(fifo_full), 32'd1);
    step_chk("full_rw", 1'b0, 1'b1, 1'b1, 8'hC3);
    chk("full_rw_dout", 32'(dout), 32'hB5);
    chk("full_rw_count", 32'(status_counter), 32'd8);
    chk("full_rw_flag", 32'(fifo_full), 32'd1);
    drain_exp = '{8'hB6, 8'hB7, 8'hB8, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hC3,
                  8'hC3, 8'hC3, 8'hC3, 8'hC3};
    for (int i = 0; i < 8; i++) begin
      step_chk($sformatf("drain%0d", i), 1'b0, 1'b0, 1'b1, 8'h00);
      chk($sformatf("drain_order%0d", i), 32'(dout), 32'(drain_exp[i]));
    end
    chk("drain_empty", 32'(fifo_empty), 32'd1);

    // Reset mid-operation with five entries stored, requests asserted alongside.
    for (int i = 0; i < 5; i++) step_chk($sformatf("mid_wr%0d", i), 1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    step_chk("mid_rd", 1'b0, 1'b0, 1'b1, 8'h00);
    step_chk("mid_wr5", 1'b0, 1'b1, 1'b0, 8'h45);
    step_chk("mid_rst", 1'b1, 1'b1, 1'b1, 8'h99);
    chk("mid_rst_count", 32'(status_counter), 32'd0);
    chk("mid_rst_empty", 32'(fifo_empty), 32'd1);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    step_chk("mid_post_rd", 1'b0, 1'b0, 1'b1, 8'h00);
    chk("mid_post_rd_dout", 32'(dout), 32'd0);
    chk("mid_post_rd_count", 32'(status_counter), 32'd0);
    step_chk("mid_post_wr", 1'b0, 1'b1, 1'b0, 8'h3C);
    step_chk("mid_post_rd2", 1'b0, 1'b0, 1'b1, 8'h00);
    chk("mid_post_value", 32'(dout), 32'h3C);

    // Random traffic against the queue model, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      step_chk($sformatf("rnd%0d", n),
               ($urandom_range(0, 99) == 0),
               ($urandom_range(0, 99) < 55),
               ($urandom_range(0, 99) < 50),
               8'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
